// File: rtl/multicycle_controller.sv
// Sequencing controller for the multi-cycle RISC-V datapath.
// Memory is handshaked through mem_ready. Every datapath enable and mux select comes from here.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   FETCH     | read instruction at PC, load IR, PC <= PC+4
//   DECODE    | latch opcode, ALUOut <= old PC + imm (branch/jal target)
//   EXEC_R    | ALU rs1 op rs2
//   EXEC_I    | ALU rs1 op imm
//   MEM_ADDR  | ALUOut <= rs1 + imm (load/store address)
//   MEM_RD    | data read at ALUOut, wait for mem_ready
//   MEM_WB    | rd <= MDR
//   MEM_WR    | data write at ALUOut, wait for mem_ready
//   BRANCH    | compare rs1/rs2, PC <= target if zero
//   JAL       | rd <= PC (already +4), PC <= target
//   LUI       | ALUOut <= 0 + imm
//   ALU_WB    | rd <= ALUOut
//   TRAP      | unsupported opcode, parked until reset
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_src,
   output logic       ir_write,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       branch,
   output logic       retire,
   output logic       illegal,
   output logic [3:0] state
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WB   = 4'd6,
      S_MEM_WR   = 4'd7,
      S_BRANCH   = 4'd8,
      S_JAL      = 4'd9,
      S_LUI      = 4'd10,
      S_ALU_WB   = 4'd11,
      S_TRAP     = 4'd12
   } state_t;

   state_t     state_q;
   logic [6:0] op_q;
   logic       illegal_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         op_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH:    if (mem_ready) state_q <= S_DECODE;
            S_DECODE: begin
               op_q <= opcode;
               case (opcode)
                  OP_R:               state_q <= S_EXEC_R;
                  OP_I:               state_q <= S_EXEC_I;
                  OP_LOAD, OP_STORE:  state_q <= S_MEM_ADDR;
                  OP_BRANCH:          state_q <= S_BRANCH;
                  OP_JAL:             state_q <= S_JAL;
                  OP_LUI:             state_q <= S_LUI;
                  default: begin
                     state_q   <= S_TRAP;
                     illegal_q <= 1'b1;
                  end
               endcase
            end
            S_EXEC_R:   state_q <= S_ALU_WB;
            S_EXEC_I:   state_q <= S_ALU_WB;
            S_LUI:      state_q <= S_ALU_WB;
            S_ALU_WB:   state_q <= S_FETCH;
            // opcode input may have moved on; only the latched copy is trusted here
            S_MEM_ADDR: state_q <= (op_q == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_q <= S_MEM_WB;
            S_MEM_WB:   state_q <= S_FETCH;
            S_MEM_WR:   if (mem_ready) state_q <= S_FETCH;
            S_BRANCH:   state_q <= S_FETCH;
            S_JAL:      state_q <= S_FETCH;
            S_TRAP:     state_q <= S_TRAP;
            default:    state_q <= S_FETCH;
         endcase
      end
   end

   // Outputs decode the current state (plus mem_ready/zero) so strobes land in the same cycle.
   always_comb begin
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      ir_write  = 1'b0;
      iord      = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      wb_sel    = 2'b00;
      alu_src_a = 2'b00;
      alu_src_b = 2'b00;
      alu_op    = 2'b00;
      branch    = 1'b0;
      retire    = 1'b0;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
               end
            end
            S_DECODE: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b10;
            end
            S_EXEC_R: begin
               alu_src_a = 2'b01;
               alu_op    = 2'b10;
            end
            S_EXEC_I: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b10;
               alu_op    = 2'b10;
            end
            S_LUI: begin
               alu_src_a = 2'b11;
               alu_src_b = 2'b10;
            end
            S_ALU_WB: begin
               reg_write = 1'b1;
               retire    = 1'b1;
            end
            S_MEM_ADDR: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
               iord     = 1'b1;
               mem_read = 1'b1;
            end
            S_MEM_WB: begin
               reg_write = 1'b1;
               wb_sel    = 2'b01;
               retire    = 1'b1;
            end
            S_MEM_WR: begin
               iord      = 1'b1;
               mem_write = 1'b1;
               retire    = mem_ready;
            end
            S_BRANCH: begin
               alu_src_a = 2'b01;
               alu_op    = 2'b11;
               branch    = 1'b1;
               pc_src    = 1'b1;
               pc_write  = zero;
               retire    = 1'b1;
            end
            S_JAL: begin
               reg_write = 1'b1;
               wb_sel    = 2'b10;
               pc_write  = 1'b1;
               pc_src    = 1'b1;
               retire    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign illegal = illegal_q & ~reset;
   assign state   = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each step pushes the expected state and
// output vector to a scoreboard, then pops and checks it mid-cycle.
module tb_multicycle_controller;

   logic       clk;
   logic       reset;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write;
   logic [1:0] wb_sel, alu_src_a, alu_src_b, alu_op;
   logic       branch, retire, illegal;
   logic [3:0] state;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
      .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .branch(branch), .retire(retire), .illegal(illegal), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
   //  wb_sel, alu_src_a, alu_src_b, alu_op, branch, retire, illegal}
   function automatic logic [17:0] ov(input logic pw, ps, irw, io, mr, mw, rw,
                                      input logic [1:0] wb, a, b, op,
                                      input logic br, ret, ill);
      return {pw, ps, irw, io, mr, mw, rw, wb, a, b, op, br, ret, ill};
   endfunction

   localparam logic [17:0] O_ZERO     = 18'd0;
   localparam logic [17:0] O_F_WAIT   = ov(0,0,0,0,1,0,0, 2'd0,2'd0,2'd1,2'd0, 0,0,0);
   localparam logic [17:0] O_F_GO     = ov(1,0,1,0,1,0,0, 2'd0,2'd0,2'd1,2'd0, 0,0,0);
   localparam logic [17:0] O_DECODE   = ov(0,0,0,0,0,0,0, 2'd0,2'd2,2'd2,2'd0, 0,0,0);
   localparam logic [17:0] O_EXEC_R   = ov(0,0,0,0,0,0,0, 2'd0,2'd1,2'd0,2'd2, 0,0,0);
   localparam logic [17:0] O_EXEC_I   = ov(0,0,0,0,0,0,0, 2'd0,2'd1,2'd2,2'd2, 0,0,0);
   localparam logic [17:0] O_LUI      = ov(0,0,0,0,0,0,0, 2'd0,2'd3,2'd2,2'd0, 0,0,0);
   localparam logic [17:0] O_ALU_WB   = ov(0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, 0,1,0);
   localparam logic [17:0] O_MEM_ADDR = ov(0,0,0,0,0,0,0, 2'd0,2'd1,2'd2,2'd0, 0,0,0);
   localparam logic [17:0] O_MEM_RD   = ov(0,0,0,1,1,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0,0);
   localparam logic [17:0] O_MEM_WB   = ov(0,0,0,0,0,0,1, 2'd1,2'd0,2'd0,2'd0, 0,1,0);
   localparam logic [17:0] O_WR_WAIT  = ov(0,0,0,1,0,1,0, 2'd0,2'd0,2'd0,2'd0, 0,0,0);
   localparam logic [17:0] O_WR_GO    = ov(0,0,0,1,0,1,0, 2'd0,2'd0,2'd0,2'd0, 0,1,0);
   localparam logic [17:0] O_BR_T     = ov(1,1,0,0,0,0,0, 2'd0,2'd1,2'd0,2'd3, 1,1,0);
   localparam logic [17:0] O_BR_N     = ov(0,1,0,0,0,0,0, 2'd0,2'd1,2'd0,2'd3, 1,1,0);
   localparam logic [17:0] O_JAL      = ov(1,1,0,0,0,0,1, 2'd2,2'd0,2'd0,2'd0, 0,1,0);
   localparam logic [17:0] O_TRAP     = ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0,1);

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   typedef struct {
      logic [3:0]  st;
      logic [17:0] outs;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic step(input logic rst, input logic mr, input logic [6:0] op, input logic z,
                       input logic [3:0] exp_st, input logic [17:0] exp_o, input string tag);
      exp_t e;
      logic [17:0] got;
      @(negedge clk);
      reset     = rst;
      mem_ready = mr;
      opcode    = op;
      zero      = z;
      sb.push_back('{st: exp_st, outs: exp_o, tag: tag});
      #1;
      e   = sb.pop_front();
      got = {pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
             wb_sel, alu_src_a, alu_src_b, alu_op, branch, retire, illegal};
      tests++;
      assert (state === e.st) else begin
         fails++;
         $error("FAIL %s state: got %0d expected %0d", e.tag, state, e.st);
      end
      tests++;
      assert (got === e.outs) else begin
         fails++;
         $error("FAIL %s outputs: got %05h expected %05h", e.tag, got, e.outs);
      end
   endtask

   initial begin
      reset = 1'b1; mem_ready = 1'b0; opcode = 7'd0; zero = 1'b0;

      step(1, 1, OP_R, 0, 4'd0, O_ZERO, "reset0");
      step(1, 1, OP_R, 0, 4'd0, O_ZERO, "reset1");

      // R-type, no stalls
      step(0, 1, OP_BAD, 0, 4'd0,  O_F_GO,   "r_fetch");
      step(0, 1, OP_R,   0, 4'd1,  O_DECODE, "r_decode");
      step(0, 1, OP_BAD, 0, 4'd2,  O_EXEC_R, "r_exec");
      step(0, 1, OP_BAD, 0, 4'd11, O_ALU_WB, "r_wb");

      // Load with 2 fetch waits and 3 read waits; opcode changes after DECODE
      step(0, 0, OP_ST, 0, 4'd0, O_F_WAIT,   "ld_fwait1");
      step(0, 0, OP_ST, 0, 4'd0, O_F_WAIT,   "ld_fwait2");
      step(0, 1, OP_ST, 0, 4'd0, O_F_GO,     "ld_fetch");
      step(0, 1, OP_LD, 0, 4'd1, O_DECODE,   "ld_decode");
      step(0, 1, OP_ST, 0, 4'd4, O_MEM_ADDR, "ld_addr");
      step(0, 0, OP_ST, 0, 4'd5, O_MEM_RD,   "ld_rwait1");
      step(0, 0, OP_ST, 0, 4'd5, O_MEM_RD,   "ld_rwait2");
      step(0, 0, OP_ST, 0, 4'd5, O_MEM_RD,   "ld_rwait3");
      step(0, 1, OP_ST, 0, 4'd5, O_MEM_RD,   "ld_rdone");
      step(0, 0, OP_ST, 0, 4'd6, O_MEM_WB,   "ld_wb");

      // Branch taken, then not taken
      step(0, 1, OP_BAD, 1, 4'd0, O_F_GO,   "bt_fetch");
      step(0, 1, OP_BR,  1, 4'd1, O_DECODE, "bt_decode");
      step(0, 1, OP_BAD, 1, 4'd8, O_BR_T,   "bt_branch");
      step(0, 1, OP_BAD, 0, 4'd0, O_F_GO,   "bn_fetch");
      step(0, 1, OP_BR,  0, 4'd1, O_DECODE, "bn_decode");
      step(0, 1, OP_BAD, 0, 4'd8, O_BR_N,   "bn_branch");

      // Store then JAL back to back
      step(0, 1, OP_BAD, 0, 4'd0, O_F_GO,     "st_fetch");
      step(0, 1, OP_ST,  0, 4'd1, O_DECODE,   "st_decode");
      step(0, 1, OP_LD,  0, 4'd4, O_MEM_ADDR, "st_addr");
      step(0, 1, OP_LD,  0, 4'd7, O_WR_GO,    "st_write");
      step(0, 1, OP_BAD, 0, 4'd0, O_F_GO,     "jal_fetch");
      step(0, 1, OP_JAL, 0, 4'd1, O_DECODE,   "jal_decode");
      step(0, 1, OP_BAD, 0, 4'd9, O_JAL,      "jal_exec");

      // I-type and LUI; mem_ready low outside memory states has no effect
      step(0, 1, OP_BAD, 0, 4'd0,  O_F_GO,   "i_fetch");
      step(0, 0, OP_I,   0, 4'd1,  O_DECODE, "i_decode");
      step(0, 0, OP_BAD, 0, 4'd3,  O_EXEC_I, "i_exec");
      step(0, 0, OP_BAD, 0, 4'd11, O_ALU_WB, "i_wb");
      step(0, 1, OP_BAD, 0, 4'd0,  O_F_GO,   "lui_fetch");
      step(0, 1, OP_LUI, 0, 4'd1,  O_DECODE, "lui_decode");
      step(0, 1, OP_BAD, 0, 4'd10, O_LUI,    "lui_exec");
      step(0, 1, OP_BAD, 0, 4'd11, O_ALU_WB, "lui_wb");

      // Illegal opcode parks in TRAP until reset
      step(0, 1, OP_R,   0, 4'd0, O_F_GO,   "ill_fetch");
      step(0, 1, OP_BAD, 0, 4'd1, O_DECODE, "ill_decode");
      for (int i = 0; i < 20; i++)
         step(0, i[0], OP_R, 1, 4'd12, O_TRAP, "ill_trap");
      step(1, 1, OP_R, 0, 4'd0, O_ZERO,   "ill_reset");
      step(0, 0, OP_R, 0, 4'd0, O_F_WAIT, "ill_after");

      // Reset during the second MEM_WR wait cycle abandons the store
      step(0, 1, OP_BAD, 0, 4'd0, O_F_GO,     "rs_fetch");
      step(0, 1, OP_ST,  0, 4'd1, O_DECODE,   "rs_decode");
      step(0, 1, OP_BAD, 0, 4'd4, O_MEM_ADDR, "rs_addr");
      step(0, 0, OP_BAD, 0, 4'd7, O_WR_WAIT,  "rs_wwait1");
      step(1, 1, OP_BAD, 0, 4'd0, O_ZERO,     "rs_reset");
      step(0, 0, OP_BAD, 0, 4'd0, O_F_WAIT,   "rs_after");
      step(0, 1, OP_BAD, 0, 4'd0, O_F_GO,     "rs_refetch");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore/Mealy finite-state controller that sequences the multi-cycle RISC-V datapath: shared instruction/data memory, IR, ALUOut, MDR and register file. It splits each instruction into fetch, decode, execute, memory and write-back steps. It handshakes with memory through `mem_ready` and drives every datapath enable and mux select. It replaces the single-cycle opcode decoder and covers the same opcode set: R, I-ALU, load, store, branch, JAL and LUI.

## Interface
- No parameters; state encoding is fixed (below).
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 7: IR[6:0]; sampled only in DECODE.
- `zero` in 1: ALU zero flag; sampled only in BRANCH.
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `pc_write` out 1: PC load enable.
- `pc_src` out 1: 0 = ALU result (PC+4), 1 = ALUOut (target).
- `ir_write` out 1: IR load enable.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `reg_write` out 1: register file write enable.
- `wb_sel` out 2: write-back source; 00 = ALUOut, 01 = MDR, 10 = PC (already PC+4).
- `alu_src_a` out 2: ALU A source; 00 = PC, 01 = rs1, 10 = old PC, 11 = zero.
- `alu_src_b` out 2: ALU B source; 00 = rs2, 01 = constant 4, 10 = immediate.
- `alu_op` out 2: 00 = add, 10 = funct-decoded, 11 = branch compare.
- `branch` out 1: branch compare in progress.
- `retire` out 1: one-cycle pulse in the final cycle of each instruction.
- `illegal` out 1: sticky; unsupported opcode decoded.
- `state` out 4: current state, for debug and the bench.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, BRANCH=8, JAL=9, LUI=10, ALU_WB=11, TRAP=12. Codes 13-15 are unreachable; if entered, the next state is FETCH.
- Any output not listed for a state is 0.
- FETCH: `iord`=0, `mem_read`=1, `alu_src_a`=00, `alu_src_b`=01, `alu_op`=00.
  - `mem_ready`=0: stay in FETCH.
  - `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=0, then go to DECODE.
- DECODE: `alu_src_a`=10, `alu_src_b`=10, `alu_op`=00; computes the target into ALUOut. Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 0110111 → LUI
  - anything else → TRAP
- EXEC_R: A=01, B=00, op=10, then ALU_WB.
- EXEC_I: A=01, B=10, op=10, then ALU_WB.
- LUI: A=11, B=10, op=00, then ALU_WB.
- ALU_WB: `reg_write`=1, `wb_sel`=00, `retire`=1, then FETCH.
- MEM_ADDR: A=01, B=10, op=00. Next is MEM_RD if the latched opcode is a load, else MEM_WR. The opcode is latched internally in DECODE.
- MEM_RD: `iord`=1, `mem_read`=1; hold until `mem_ready`=1, then MEM_WB.
- MEM_WB: `reg_write`=1, `wb_sel`=01, `retire`=1, then FETCH.
- MEM_WR: `iord`=1, `mem_write`=1; hold until `mem_ready`=1. In that cycle `retire`=1, then FETCH.
- BRANCH: A=01, B=00, op=11, `branch`=1, `pc_src`=1, `pc_write`=`zero`, `retire`=1, then FETCH.
- JAL: `reg_write`=1, `wb_sel`=10, `pc_write`=1, `pc_src`=1, `retire`=1, then FETCH.
- TRAP: all strobes 0, `illegal`=1; stays in TRAP until `reset`.

## Timing
- Reset: a `reset` high at an edge forces `state`=FETCH, clears `illegal` and clears the latched opcode.
- While `reset` is high, all outputs are forced to 0, including FETCH's `mem_read`.
- FETCH begins requesting memory in the first cycle after `reset` deasserts.
- Reset has priority over everything, including mid-wait in FETCH, MEM_RD or MEM_WR. Any pending memory access is abandoned with no `retire`.
- Cycle counts with `mem_ready` held high:
  - R, I and LUI: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch and JAL: 3 cycles.
- Each memory wait cycle adds exactly 1 cycle.
- `mem_read` / `mem_write` stay asserted, with `iord` stable, for every wait cycle until `mem_ready` is sampled high.
- `mem_ready` has no effect outside FETCH, MEM_RD and MEM_WR.
- `retire` is asserted for exactly one cycle per completed instruction and never in TRAP.
- Only the opcode latched in DECODE is used after DECODE; changes on `opcode` in later cycles are ignored.

## Test plan
- R-type: reset, `mem_ready`=1, `opcode`=0110011 → `state` sequence 0,1,2,11,0; `reg_write`=1 and `retire`=1 only in state 11.
- Load with memory stalls: `opcode`=0000011, `mem_ready`=0 for 2 cycles in FETCH and 3 cycles in MEM_RD → total 10 cycles; `mem_read`=1 and `iord`=1 on all 4 MEM_RD cycles; `wb_sel`=01 in MEM_WB.
- Branch: `opcode`=1100011 with `zero`=1 → `pc_write`=1 and `pc_src`=1 in BRANCH. Repeat with `zero`=0 → `pc_write`=0 and `retire`=1 still asserted.
- Store then JAL back-to-back: → MEM_WR with `mem_write`=1 and no `reg_write`; then JAL with `wb_sel`=10, `reg_write`=1, `pc_write`=1; 4+3 cycles total.
- Illegal opcode: `opcode`=1111111 → TRAP; `illegal`=1 held for 20 cycles with all strobes 0. Then `reset` → `illegal`=0, `state`=0.
- Reset mid-operation: assert `reset` during the 2nd wait cycle of MEM_WR → next `state`=0, `mem_write`=0 and no `retire` pulse.
